// File: rtl/antares_div_unit_pkg.sv
// Shared constants and helpers for the iterative divider.
package antares_div_unit_pkg;

    localparam logic       ST_IDLE       = 1'b0;
    localparam logic       ST_BUSY       = 1'b1;
    localparam logic [4:0] ITER_LAST_CNT = 5'd31;

    // Two's-complement negate when neg is set; used for magnitude and sign fix-up.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/antares_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// State table: ST_IDLE | waiting for a start strobe ; ST_BUSY | running the 32 iterations
module antares_div_unit
    import antares_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_divs,
    input  logic        op_divu,
    input  logic        op_abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_stall,
    output logic        div_done
);

    logic        state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [32:0] rem_q,       rem_d;
    logic [31:0] quo_q,       quo_d;
    logic [31:0] dvsr_q,      dvsr_d;
    logic        neg_q_q,     neg_q_d;
    logic        neg_r_q,     neg_r_d;
    logic [31:0] quotient_q,  quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        done_q,      done_d;

    logic        is_signed;
    logic        start_go;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] quo_next;

    assign is_signed = op_divs;
    assign start_go  = (op_divs | op_divu) & ~op_abort;

    // The partial remainder never exceeds 32 significant bits, so a 34-bit
    // trial subtraction gives a reliable sign in bit 33.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {2'b00, dvsr_q};
    assign q_bit    = ~diff[33];
    assign rem_next = q_bit ? diff[32:0] : shifted[32:0];
    assign quo_next = {quo_q[30:0], q_bit};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ST_BUSY;
                    cnt_d   = ITER_LAST_CNT;
                    rem_d   = '0;
                    quo_d   = neg_if(is_signed & dividend[31], dividend);
                    dvsr_d  = neg_if(is_signed & divisor[31], divisor);
                    neg_q_d = is_signed & (dividend[31] ^ divisor[31]);
                    neg_r_d = is_signed & dividend[31];
                end
            end
            ST_BUSY: begin
                if (op_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = ST_IDLE;
                        // Divide-by-zero leaves the all-ones quotient uncorrected;
                        // the remainder correction restores the original dividend.
                        quotient_d  = neg_if(neg_q_q & (dvsr_q != 32'd0), quo_next);
                        remainder_d = neg_if(neg_r_q, rem_next[31:0]);
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_done  = done_q;
    assign div_stall = (state_q == ST_BUSY);

endmodule

// File: tb/tb_antares_div_unit.sv
// Directed and randomized checks of antares_div_unit against an arithmetic reference model.
module tb_antares_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_divs, op_divu, op_abort;
    logic [31:0] dividend, divisor;
    logic [31:0] quotient, remainder;
    logic        div_stall, div_done;

    int checks = 0;
    int errors = 0;

    antares_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (op_divs),
        .op_divu   (op_divu),
        .op_abort  (op_abort),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_stall (div_stall),
        .div_done  (div_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plain arithmetic reference: truncating division, remainder takes dividend's sign.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_divs  = sgn;
        op_divu  = ~sgn;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        op_divs = 1'b0;
        op_divu = 1'b0;
    endtask

    // Runs one divide; inj_at > 0 pulses a stray 9/3 start during that BUSY cycle.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int inj_at);
        logic [31:0] eq, er;
        int   n;
        logic early_done;
        model(sgn, a, b, eq, er);
        start_op(sgn, a, b);
        n = 0;
        early_done = 1'b0;
        while (div_stall === 1'b1 && n < 40) begin
            n++;
            if (div_done !== 1'b0) early_done = 1'b1;
            if (n == inj_at) begin
                op_divu  = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                op_divu = 1'b0;
            end
            @(negedge clk);
        end
        op_divu = 1'b0;
        chk({tag, "/stall_cycles"}, n, 32);
        chk({tag, "/early_done"}, {31'd0, early_done}, 32'd0);
        chk({tag, "/done"}, {31'd0, div_done}, 32'd1);
        chk({tag, "/quotient"}, quotient, eq);
        chk({tag, "/remainder"}, remainder, er);
        @(negedge clk);
        chk({tag, "/done_pulse"}, {31'd0, div_done}, 32'd0);
        chk({tag, "/hold_q"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          n;

        rst = 1'b1; op_divs = 1'b0; op_divu = 1'b0; op_abort = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset/quotient", quotient, 32'd0);
        chk("reset/remainder", remainder, 32'd0);
        chk("reset/stall", {31'd0, div_stall}, 32'd0);
        chk("reset/done", {31'd0, div_done}, 32'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("u_max_1_inj", 1'b0, 32'hFFFF_FFFF, 32'd1, 5);

        // Abort mid-operation after a completed 100/7.
        run_div("u100_7b", 1'b0, 32'd100, 32'd7, 0);
        start_op(1'b0, 32'd50, 32'd5);
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        op_abort = 1'b1;
        @(negedge clk);
        op_abort = 1'b0;
        chk("abort/stall", {31'd0, div_stall}, 32'd0);
        chk("abort/done", {31'd0, div_done}, 32'd0);
        chk("abort/quotient", quotient, 32'd14);
        chk("abort/remainder", remainder, 32'd2);
        run_div("u50_5", 1'b0, 32'd50, 32'd5, 0);

        // Abort beats a start presented in the same IDLE cycle.
        @(negedge clk);
        op_abort = 1'b1; op_divu = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        op_abort = 1'b0; op_divu = 1'b0;
        chk("abort_vs_start/stall", {31'd0, div_stall}, 32'd0);

        run_div("u_div0", 1'b0, 32'd1234, 32'd0, 0);
        run_div("s_div0", 1'b1, 32'hFFFF_FF00, 32'd0, 0);

        // Reset mid-operation.
        start_op(1'b0, 32'd77, 32'd3);
        n = 1;
        while (n < 7) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/quotient", quotient, 32'd0);
        chk("midrst/remainder", remainder, 32'd0);
        chk("midrst/stall", {31'd0, div_stall}, 32'd0);
        chk("midrst/done", {31'd0, div_done}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            rs = $urandom_range(0, 1);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(1, 15);
                1:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) rb = 32'd1;
            run_div($sformatf("rand%0d", i), rs, ra, rb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/antares_div_unit.md
# antares_div_unit

Iterative 32-bit signed/unsigned divider. It is the responder side of the ALU's DIV/DIVU handshake. It accepts a one-cycle start strobe with dividend and divisor. It computes one quotient bit per cycle (radix-2 restoring), holds `div_stall` high while busy, and presents stable quotient/remainder for the HILO write once `div_stall` falls. It sits in the EX stage beside the multiplier.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- op_divs  in  1  start signed division (single-cycle strobe)
- op_divu  in  1  start unsigned division (single-cycle strobe)
- op_abort  in  1  cancel in-flight division (pipeline flush)
- dividend  in  32  sampled on accepted start
- divisor  in  32  sampled on accepted start
- quotient  out  32  registered result; valid when `div_stall` falls
- remainder  out  32  registered result; valid when `div_stall` falls
- div_stall  out  1  high while an operation is in flight
- div_done  out  1  one-cycle pulse on the first cycle results are valid

## Operation
- States:
  - IDLE: waits for a start.
  - BUSY: runs the 32 iterations.
- Start accepted:
  - Condition: state IDLE, `op_divs|op_divu`, `op_abort` low.
  - If both strobes are high, `op_divs` wins.
  - Latch:
    - `|dividend|` and `|divisor|`; signed op uses two's-complement magnitude, unsigned op uses raw values.
    - `neg_q = dividend[31]^divisor[31]` (signed only).
    - `neg_r = dividend[31]` (signed only).
  - Clear the 33-bit partial remainder and load the 5-bit counter with 31.
- BUSY, each cycle:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep it and shift in quotient bit 1; else keep the shifted value and shift in 0.
  - Decrement the counter.
- On the iteration with counter==0:
  - Write `quotient` = `neg_q` ? −q : q.
  - Write `remainder` = `neg_r` ? −r : r.
  - Return to IDLE and set `div_done`.
- Arithmetic:
  - Results are mod 2^32.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. No trap.
- Divisor zero (not issued by the ALU, still defined):
  - Full 32 cycles.
  - quotient=0xFFFFFFFF, remainder=dividend.
  - No sign correction.
- Start while BUSY: ignored; the in-flight operation is unaffected.
- `op_abort`:
  - In BUSY: return to IDLE at the next edge.
  - `quotient`/`remainder` keep their previous values.
  - No `div_done`.
  - Abort beats start in the same cycle.
- Reset:
  - Applies at any time, including mid-operation.
  - Values: state IDLE, `quotient`=0, `remainder`=0, `div_stall`=0, `div_done`=0, counter 0.

## Timing
- Start sampled at edge E0. `div_stall` is low during the start cycle; the ALU's own active flag covers that cycle.
- `div_stall` (= state==BUSY) is high after E0 through E32, exactly 32 cycles.
- Final iteration at E32. After E32:
  - `div_stall`=0.
  - `div_done`=1 for one cycle.
  - `quotient`/`remainder` valid and held until the next accepted start completes.
- Earliest next start: the cycle after E32; back-to-back throughput is 33 cycles per divide.
- Abort asserted in cycle k of BUSY: `div_stall` is low from the next cycle.
- Outputs are all registered except `div_stall`, which decodes directly from the state flop.

## Structure
- State encodings (IDLE=1'b0, BUSY=1'b1) and the iteration count constant (31) go in `antares_defines.v` with the existing ALU op codes.
- Single flat module; no sub-module. The one-bit step and the sign correction are small enough to stay inline.
- Approximately 150–200 lines: state flop, counter, 33-bit remainder register, 32-bit quotient/dividend shift register, magnitude/negation logic, output registers.

## Test plan
- Unsigned 100/7:
  - Stimulus: `op_divu` for one cycle.
  - Response: `div_stall` high exactly 32 cycles, then quotient=14, remainder=2, `div_done` single pulse.
- Signed 0xFFFFFFF9 / 0x00000002 (−7/2):
  - Response: quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- Signed 0x80000000 / 0xFFFFFFFF:
  - Response: quotient=0x80000000, remainder=0.
- Unsigned 0xFFFFFFFF / 1, second start pulsed at BUSY cycle 5 with 9/3:
  - Response: second start ignored; quotient=0xFFFFFFFF, remainder=0.
- Abort:
  - Stimulus: complete 100/7, then start 50/5 and assert `op_abort` in BUSY cycle 10.
  - Response: `div_stall` low next cycle, outputs still 14/2, no `div_done`; a fresh 50/5 start next cycle yields 10/0.
- Divisor zero, then reset:
  - Divisor zero, unsigned 1234/0: quotient=0xFFFFFFFF, remainder=1234.
  - Reset: `rst` at BUSY cycle 7 gives all outputs 0 and IDLE at the next edge.
